// File: rtl/inst_fetch_unit.sv
// RV32I instruction-fetch stage: PC, I-cache req/ack, one-entry skid buffer, redirect/kill.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_kill_cnt outputs.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ack,
  input  logic [31:0] icache_rdata,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_FULL, S_KILL} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        ack_v;
  logic [31:0] redirect_target;
  logic [1:0]  unused_rpc_lo;

  // An ack only counts against a request we actually have outstanding.
  assign ack_v           = icache_ack & req_q;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_lo   = redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  // A redirect kills the in-flight transaction only if one is outstanding and not ending now.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (state_q != S_FULL && req_q && !ack_v) ? S_KILL : S_REQ;
    end else begin
      case (state_q)
        S_REQ:   if (ack_v && valid_q && stall_d) state_d = S_FULL;
        S_FULL:  if (!stall_d) state_d = S_REQ;
        S_KILL:  if (ack_v) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    ipc_d      = ipc_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    req_addr_d = req_addr_q;
    req_d      = (state_d != S_FULL);
    if (redirect) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else begin
      if (!stall_d) begin
        valid_d = 1'b0;
        inst_d  = NOP_INST;
      end
      case (state_q)
        S_REQ: begin
          if (ack_v) begin
            pc_d = pc_q + 32'd4;
            if (!valid_q || !stall_d) begin
              valid_d = 1'b1;
              inst_d  = icache_rdata;
              ipc_d   = req_addr_q;
            end else begin
              buf_inst_d = icache_rdata;
              buf_pc_d   = req_addr_q;
            end
          end
        end
        S_FULL: begin
          if (!stall_d) begin
            valid_d = 1'b1;
            inst_d  = buf_inst_q;
            ipc_d   = buf_pc_q;
          end
        end
        default: ;
      endcase
    end
    // New request address is latched only when a fresh transaction begins.
    if (req_d && (!req_q || ack_v)) req_addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      valid_q    <= 1'b0;
      inst_q     <= NOP_INST;
      ipc_q      <= '0;
      buf_inst_q <= NOP_INST;
      buf_pc_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  assign icache_req  = req_q;
  assign icache_addr = req_addr_q;
  assign if_valid    = valid_q;
  assign if_inst     = inst_q;
  assign if_pc       = ipc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (ack_v && !redirect && state_q == S_REQ) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (ack_v && (redirect || state_q == S_KILL)) kill_cnt_d = kill_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus randomized traffic vs a queue-based model.
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ack = 1'b0;
  logic [31:0] icache_rdata = '0;
  logic        stall_d = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ack(icache_ack), .icache_rdata(icache_rdata),
    .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_kill_cnt(perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Reference model: outstanding request, doomed flag, output slot, skid queue.
  logic [31:0] m_pc, m_addr, m_inst, m_ipc;
  logic        m_req, m_doomed, m_valid;
  logic [63:0] m_buf[$];
  logic [31:0] m_fetches, m_kills;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_inst = NOP; m_ipc = 32'h0;
    m_req = 1'b0; m_doomed = 1'b0; m_valid = 1'b0;
    m_buf.delete();
    m_fetches = 32'h0; m_kills = 32'h0;
  endtask

  task automatic model_step();
    logic ack, keep_full;
    logic [63:0] e;
    ack = icache_ack && m_req;
    if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_valid = 1'b0; m_inst = NOP;
      m_buf.delete();
      if (m_req) begin
        if (ack) begin m_kills++; m_req = 1'b0; end
        else m_doomed = 1'b1;
      end
    end else begin
      keep_full = m_valid && stall_d;
      if (!stall_d) begin m_valid = 1'b0; m_inst = NOP; end
      if (ack) begin
        m_req = 1'b0;
        if (m_doomed) m_kills++;
        else begin
          m_fetches++;
          m_pc = m_pc + 32'd4;
          if (keep_full) m_buf.push_back({icache_rdata, m_addr});
          else begin m_valid = 1'b1; m_inst = icache_rdata; m_ipc = m_addr; end
        end
      end else if (m_buf.size() > 0 && !stall_d) begin
        e = m_buf.pop_front();
        m_valid = 1'b1; m_inst = e[63:32]; m_ipc = e[31:0];
      end
    end
    if (!m_req && m_buf.size() == 0) begin
      m_req = 1'b1; m_addr = m_pc; m_doomed = 1'b0;
    end
  endtask

  task automatic compare();
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("if_inst", if_inst, m_inst);
    chk("if_pc", if_pc, m_ipc);
    chk("icache_req", {31'b0, icache_req}, {31'b0, m_req});
    chk("icache_addr", icache_addr, m_addr);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fetches);
    chk("perf_kill_cnt", perf_kill_cnt, m_kills);
`endif
  endtask

  task automatic step(input logic ack, input logic stl, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    icache_ack   = ack & icache_req;
    icache_rdata = mem(icache_addr);
    stall_d      = stl;
    redirect     = rd;
    redirect_pc  = rpc;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    icache_ack = 1'b0; redirect = 1'b0; stall_d = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_inst", if_inst, NOP);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_icache_req", {31'b0, icache_req}, 32'h0);
    chk("rst_icache_addr", icache_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #3;
    do_reset();

    // Back-to-back hits: addr leads if_pc by one cycle.
    step(1'b0, 1'b0, 1'b0, '0);
    chk("first_req", {31'b0, icache_req}, 32'h1);
    chk("first_addr", icache_addr, 32'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      chk("b2b_if_pc", if_pc, i * 4);
      chk("b2b_addr", icache_addr, i * 4 + 4);
    end

    // Miss on 0x10: address held, slot empty until ack.
    for (int unsigned i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      chk("miss_addr", icache_addr, 32'h10);
      chk("miss_valid", {31'b0, if_valid}, 32'h0);
    end
    step(1'b1, 1'b0, 1'b0, '0);
    chk("miss_inst", if_inst, mem(32'h10));
    chk("miss_pc", if_pc, 32'h10);

    // Stall with a returning ack parks the word in the skid buffer.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("full_req", {31'b0, icache_req}, 32'h0);
    chk("full_pc", if_pc, 32'h14);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("drain_pc", if_pc, 32'h18);
    chk("drain_valid", {31'b0, if_valid}, 32'h1);
    chk("drain_addr", icache_addr, 32'h1C);
    step(1'b0, 1'b0, 1'b0, '0);

    // Redirect mid-transaction: kill and refetch from aligned target.
    step(1'b0, 1'b0, 1'b1, 32'h103);
    chk("kill_addr", icache_addr, 32'h1C);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("kill_hold", icache_addr, 32'h1C);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("kill_valid", {31'b0, if_valid}, 32'h0);
    chk("kill_next_addr", icache_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("kill_cnt_lit", perf_kill_cnt, 32'h1);
`endif

    // Redirect with ack and stall in the same cycle.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("rdack_valid", {31'b0, if_valid}, 32'h0);
    chk("rdack_inst", if_inst, NOP);
    chk("rdack_addr", icache_addr, 32'h200);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("wrap_pre", icache_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", icache_addr, 32'h0);

    // Randomized traffic with occasional mid-run resets.
    for (int unsigned i = 0; i < 4000; i++) begin
      if (i % 1500 == 1499) do_reset();
      step($urandom_range(99) < 55, $urandom_range(99) < 30,
           $urandom_range(99) < 6, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of decode, whose immediate decoder consumes if_inst.
- Owns the PC and issues word requests to the I-cache over a req/ack handshake that tolerates multi-cycle misses.
- Holds a one-entry skid buffer so that a decode stall never loses a returned instruction.
- Handles branch/jump redirects, including one that lands mid-transaction.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INST, 32'h0000_0013, bubble inserted on if_inst (addi x0,x0,0).

Ports:
clk  in  1  Core clock; all state updates on the rising edge.
rst_n  in  1  Asynchronous active-low reset.
icache_req  out  1  Fetch request to the I-cache.
icache_addr  out  32  Word-aligned fetch address; stable while icache_req=1 and icache_ack=0.
icache_ack  in  1  One-cycle pulse; icache_rdata is valid in the same cycle.
icache_rdata  in  32  Returned instruction word.
stall_d  in  1  Decode cannot accept a new instruction this cycle.
redirect  in  1  Branch/jump taken; refetch from redirect_pc.
redirect_pc  in  32  Target address; bits [1:0] are ignored and forced to 0.
if_valid  out  1  if_inst and if_pc hold a live instruction for decode.
if_inst  out  32  Instruction to decode.
if_pc  out  32  PC of if_inst.

Behaviour:
- Reset (asynchronous):
  - pc=RESET_PC, state=S_REQ, buffer empty.
  - if_valid=0, if_inst=NOP_INST, if_pc=0, icache_req=0, icache_addr=0.
  - icache_req goes to 1 in the first cycle after release, with icache_addr=RESET_PC.
- Registers:
  - icache_addr comes from a req_addr register, loaded from pc when a request starts. It never changes while the request is outstanding.
  - pc advances by pc+4 (32-bit wrap, FFFF_FFFC -> 0000_0000) on every accepted, non-killed ack.
- Output slot consumption: the slot is consumed in any cycle with stall_d=0. If nothing new is loaded that cycle, if_valid drops to 0 and if_inst becomes NOP_INST.
- State S_REQ: icache_req=1. On icache_ack:
  - If the slot is free or being consumed (if_valid=0 or stall_d=0): load the slot (if_valid=1, if_inst=rdata, if_pc=req_addr). Start the next request the following cycle, so the best-case latency is ack-to-ack 1 cycle (back-to-back).
  - If if_valid=1 and stall_d=1: write rdata and req_addr into the buffer and go to S_FULL.
- State S_FULL: icache_req=0. When stall_d=0, move the buffer into the slot (if_valid stays 1) and go to S_REQ.
- State S_KILL: icache_req=1 with the old req_addr. On ack, discard rdata and go to S_REQ; the next request uses the already-updated pc.
- redirect has the highest priority, in every state:
  - pc <= {redirect_pc[31:2],2'b00}.
  - Slot and buffer are cleared: if_valid=0, if_inst=NOP_INST.
  - In S_REQ with no ack that cycle, go to S_KILL. The cache transaction is never aborted; req stays held until ack.
  - In S_REQ with ack the same cycle, discard rdata and go to S_REQ with the new address next cycle.
  - In S_FULL, go to S_REQ.
  - In S_KILL, stay in S_KILL with the updated pc.
- stall_d together with redirect: redirect wins and the slot is flushed.
- Simultaneous stall_d=0 and ack in S_REQ: the current slot is consumed and replaced in the same edge; no bubble.
- rst_n asserted mid-transaction: immediate reset. The cache is required to reset in the same domain, so no orphan ack is expected.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0], counting accepted non-killed acks.
  - Adds perf_kill_cnt[31:0], counting acks discarded due to redirect.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor the counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset, ack every cycle, stall_d=0:
  - if_pc sequence 0,4,8,C on consecutive cycles after the first ack.
  - icache_addr leads if_pc by one cycle.
- Miss: ack 5 cycles after req for addr 0x8 -> icache_addr holds 0x8 for all 5 cycles; if_valid=0 until ack, then if_inst=rdata, if_pc=0x8.
- stall_d=1 for 3 cycles with if_valid=1, ack arrives:
  - Goes to S_FULL with icache_req=0.
  - After stall_d falls, if_pc takes the buffered 0xC the next cycle; no instruction is lost or duplicated.
- Redirect to 0x103 while a request for 0x10 waits for ack:
  - Enters S_KILL and holds addr 0x10 until ack; that rdata never appears.
  - Next request addr is 0x100.
  - With FETCH_PERF_CNT_EN: perf_kill_cnt=1.
- Redirect to 0x200 in the same cycle as ack for 0x14 while stall_d=1:
  - Next cycle if_valid=0, if_inst=0x0000_0013, icache_addr=0x200.
- pc=0xFFFF_FFFC fetched and acked -> next icache_addr=0x0000_0000.
